seg7_scan_driver: RTL and testbench

Time-multiplexed eight-digit seven-segment driver for the board top level. It consumes a 32-bit word through a single-cycle load strobe and shows it as eight hex digits. The refresh scan is continuous, and each new word is committed only at a frame boundary, so a scan never shows a mix of old and new digits. It is the display-side end of the `data` path that the board's operand/result selector feeds.

---
 rtl/seg7_scan_driver.sv | 125 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Eight-digit time-multiplexed hex display driver with frame-aligned commit.
// Optional leading-zero blanking via SEG7_LZ_BLANK_EN.
module seg7_scan_driver #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] data,
  input  logic [7:0]  dp_mask,
  output logic [2:0]  which,
  output logic [7:0]  seg,
  output logic        pending
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);

  logic [DW-1:0] r_div;
  logic [2:0]    r_which;
  logic [7:0]    r_seg;
  logic          r_pending;
  logic [31:0]   r_sh_data;
  logic [7:0]    r_sh_dp;
  logic [31:0]   r_act_data;
  logic [7:0]    r_act_dp;

  logic          w_tick;
  logic          w_bnd;
  logic [2:0]    w_which_nx;
  logic [31:0]   w_act_data;
  logic [7:0]    w_act_dp;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] enc(
    input logic [31:0] w,
    input logic [7:0]  m,
    input logic [2:0]  k
  );
    logic [31:0] sh;
    logic [6:0]  s;
    sh = w >> {k, 2'b00};
    s  = hex7(sh[3:0]);
`ifdef SEG7_LZ_BLANK_EN
    // Blank when this and every higher nibble is zero.
    if (k != 3'd0 && sh == 32'd0)
      s = 7'h7F;
`endif
    return {~m[k], s};
  endfunction

  assign w_tick     = (r_div == DIV_MAX);
  assign w_bnd      = w_tick && (r_which == 3'd7);
  assign w_which_nx = r_which + 3'd1;

  // Active word as it stands after this edge.
  always_comb begin
    w_act_data = r_act_data;
    w_act_dp   = r_act_dp;
    if (w_bnd) begin
      if (load) begin
        w_act_data = data;
        w_act_dp   = dp_mask;
      end else if (r_pending) begin
        w_act_data = r_sh_data;
        w_act_dp   = r_sh_dp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div      <= '0;
      r_which    <= 3'd0;
      r_seg      <= 8'hFF;
      r_pending  <= 1'b0;
      r_sh_data  <= 32'd0;
      r_sh_dp    <= 8'd0;
      r_act_data <= 32'd0;
      r_act_dp   <= 8'd0;
    end else begin
      r_div      <= w_tick ? '0 : r_div + 1'b1;
      r_act_data <= w_act_data;
      r_act_dp   <= w_act_dp;
      if (w_tick) begin
        r_which <= w_which_nx;
        r_seg   <= enc(w_act_data, w_act_dp, w_which_nx);
      end
      if (load) begin
        r_sh_data <= data;
        r_sh_dp   <= dp_mask;
        r_pending <= !w_bnd;
      end else if (w_bnd) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign which   = r_which;
  assign seg     = r_seg;
  assign pending = r_pending;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed table plus randomized run against a frame-arithmetic model.
// Honours SEG7_LZ_BLANK_EN when defined for the build.
module tb_seg7_scan_driver;

  localparam int SD = 4;
`ifdef SEG7_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif
  localparam logic [7:0] Z1 = LZ ? 8'hFF : 8'hC0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [31:0] data = '0;
  logic [7:0]  dp_mask = '0;
  logic [2:0]  which;
  logic [7:0]  seg;
  logic        pending;

  seg7_scan_driver #(.SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .load(load), .data(data),
    .dp_mask(dp_mask), .which(which), .seg(seg),
    .pending(pending)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;

  // Model state: edges since reset, active/shadow words.
  int          m_c = 0;
  logic [31:0] m_act = '0, m_sh = '0;
  logic [7:0]  m_adp = '0, m_sdp = '0;
  bit          m_pend = 1'b0;

  logic [6:0] hexv [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [7:0] m_seg(int k);
    logic [31:0] hi;
    logic [6:0]  s;
    if (m_c < SD) return 8'hFF;
    hi = m_act >> (4 * k);
    s  = hexv[hi[3:0]];
    if (LZ && k > 0 && hi == 0) s = 7'h7F;
    return {~m_adp[k], s};
  endfunction

  task automatic check(string nm, logic [2:0] ew,
                       logic [7:0] es, bit ep);
    nvec++;
    if (which !== ew || seg !== es || pending !== ep) begin
      nmis++;
      $display("FAIL %s: got which=%0d seg=%h pend=%b, want which=%0d seg=%h pend=%b",
               nm, which, seg, pending, ew, es, ep);
    end
  endtask

  task automatic cyc(bit r, bit l, logic [31:0] d, logic [7:0] m);
    int k;
    bit bnd;
    rst = r; load = l; data = d; dp_mask = m;
    @(posedge clk);
    if (r) begin
      m_c = 0; m_act = 0; m_sh = 0; m_adp = 0; m_sdp = 0; m_pend = 0;
    end else begin
      m_c++;
      bnd = (m_c % (8 * SD)) == 0;
      if (l) begin
        m_sh = d; m_sdp = m;
        if (bnd) begin m_act = d; m_adp = m; m_pend = 0; end
        else m_pend = 1;
      end else if (bnd && m_pend) begin
        m_act = m_sh; m_adp = m_sdp; m_pend = 0;
      end
    end
    @(negedge clk);
    k = (m_c / SD) % 8;
    check("model", 3'(k), m_seg(k), m_pend);
  endtask

  typedef struct {
    bit          r;
    bit          l;
    logic [31:0] d;
    logic [7:0]  m;
    int          idle;
    logic [2:0]  ew;
    logic [7:0]  es;
    bit          ep;
  } vec_t;

  vec_t tbl [21];

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 8'hFF, 0};
    tbl[1]  = '{0, 0, 0, 0, 2, 0, 8'hFF, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 1, Z1, 0};
    tbl[3]  = '{0, 1, 32'h89ABCDEF, 8'h01, 0, 1, Z1, 1};
    tbl[4]  = '{0, 0, 0, 0, 26, 0, 8'h0E, 0};
    tbl[5]  = '{0, 0, 0, 0, 3, 1, 8'h86, 0};
    tbl[6]  = '{0, 1, 32'h11111111, 8'h00, 0, 1, 8'h86, 1};
    tbl[7]  = '{0, 1, 32'h22222222, 8'h00, 0, 1, 8'h86, 1};
    tbl[8]  = '{0, 0, 0, 0, 25, 0, 8'hA4, 0};
    tbl[9]  = '{0, 0, 0, 0, 26, 6, 8'hA4, 0};
    tbl[10] = '{0, 0, 0, 0, 3, 7, 8'hA4, 0};
    tbl[11] = '{0, 1, 32'h12345678, 8'h00, 0, 0, 8'h80, 0};
    tbl[12] = '{0, 0, 0, 0, 3, 1, 8'hF8, 0};
    tbl[13] = '{0, 1, 32'hFFFFFFFF, 8'hFF, 0, 1, 8'hF8, 1};
    tbl[14] = '{1, 0, 0, 0, 0, 0, 8'hFF, 0};
    tbl[15] = '{0, 0, 0, 0, 35, 1, Z1, 0};
    tbl[16] = '{0, 1, 32'h000000A0, 8'h10, 0, 1, Z1, 1};
    tbl[17] = '{0, 0, 0, 0, 26, 0, 8'hC0, 0};
    tbl[18] = '{0, 0, 0, 0, 3, 1, 8'h88, 0};
    tbl[19] = '{0, 0, 0, 0, 11, 4, LZ ? 8'h7F : 8'h40, 0};
    tbl[20] = '{0, 0, 0, 0, 3, 5, LZ ? 8'hFF : 8'hC0, 0};

    for (int i = 0; i < 21; i++) begin
      cyc(tbl[i].r, tbl[i].l, tbl[i].d, tbl[i].m);
      for (int j = 0; j < tbl[i].idle; j++) cyc(0, 0, 0, 0);
      check($sformatf("tbl[%0d]", i), tbl[i].ew, tbl[i].es, tbl[i].ep);
    end

    for (int i = 0; i < 4000; i++) begin
      bit r, l;
      logic [31:0] d;
      r = ($urandom_range(0, 699) == 0);
      l = ($urandom_range(0, 15) == 0);
      d = $urandom >> $urandom_range(0, 31);
      cyc(r, l, d, 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
